cpu_dcache: RTL and testbench



---
 rtl/cpu_dcache_pkg.sv | 20 ++
 rtl/cpu_dcache_ram.sv | 30 +++
 rtl/cpu_dcache.sv | 255 +++++++++++++++++++++++++
 tb/tb_cpu_dcache.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dcache_pkg.sv
// Shared definitions for the L1 data cache.
//   - state_t      : controller state encoding
//   - UNCACHED_BIT : address bit that marks an access as uncached
//   - DEFAULT_SIZE : default log2 of the number of one-word lines
package cpu_dcache_pkg;

  localparam int DEFAULT_SIZE = 8;
  localparam int UNCACHED_BIT = 31;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    FILL,
    UNCACHED,
    FLUSH_SCAN,
    FLUSH_WB
  } state_t;

endpackage

// File: rtl/cpu_dcache_ram.sv
// Synchronous single-port RAM holding {tag, data} for every cache line.
//   i_clock : clock
//   i_we    : write enable for entry i_addr
//   i_addr  : entry index (read every cycle)
//   i_wdata : entry to write
//   o_rdata : entry at i_addr, one cycle after the address is presented
//             (read-before-write when i_we is high)
module cpu_dcache_ram
  import cpu_dcache_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_SIZE,
  parameter int DATA_W = 32
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      mem[i_addr] <= i_wdata;
    end
    o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/cpu_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache, one 32-bit word
// per line, with a single-master bus towards memory.
//   i_clock, i_reset      : clock, synchronous active-high reset
//   i_request/i_rw/i_flush/i_address/i_wdata : client request (held until o_ready)
//   o_ready/o_rdata       : one-cycle completion strobe and read data
//   o_bus_request/o_bus_rw/o_bus_address/o_bus_wdata : registered bus request
//   i_bus_ready/i_bus_rdata : bus completion and read data
// Handshakes: a client transaction completes in the single cycle o_ready is
// high; a request still present in the following cycle is a new transaction.
// A bus transaction is presented with o_bus_request high and held stable until
// the cycle i_bus_ready is high; the request then drops for at least one cycle.
module cpu_dcache
  import cpu_dcache_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  input  logic        i_rw,
  input  logic        i_request,
  input  logic        i_flush,
  output logic        o_ready,
  input  logic [31:0] i_address,
  output logic [31:0] o_rdata,
  input  logic [31:0] i_wdata
);

  localparam int LINES   = 1 << SIZE;
  localparam int TAG_W   = 30 - SIZE;
  localparam int ENTRY_W = TAG_W + 32;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [SIZE-1:0]   flush_idx_q, flush_idx_d;
  logic              req_rw_q, req_rw_d;
  logic [31:0]       req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic              bus_request_q, bus_request_d, bus_rw_q, bus_rw_d;
  logic [31:0]       bus_address_q, bus_address_d, bus_wdata_q, bus_wdata_d;

  logic               ram_we;
  logic [SIZE-1:0]    ram_addr;
  logic [ENTRY_W-1:0] ram_wdata, ram_rdata;

  logic [SIZE-1:0]  req_idx;
  logic [TAG_W-1:0] req_tag, line_tag;
  logic [31:0]      line_data;
  logic             hit, victim_dirty, bus_done, flush_step;

  assign req_idx      = req_addr_q[SIZE+1:2];
  assign req_tag      = req_addr_q[31:SIZE+2];
  assign line_tag     = ram_rdata[ENTRY_W-1:32];
  assign line_data    = ram_rdata[31:0];
  assign hit          = valid_q[req_idx] && (line_tag == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign bus_done     = bus_request_q && i_bus_ready;

  assign o_bus_request = bus_request_q;
  assign o_bus_rw      = bus_rw_q;
  assign o_bus_address = bus_address_q;
  assign o_bus_wdata   = bus_wdata_q;

  cpu_dcache_ram #(.ADDR_W(SIZE), .DATA_W(ENTRY_W)) u_ram (
    .i_clock (i_clock),
    .i_we    (ram_we),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    flush_idx_d   = flush_idx_q;
    req_rw_d      = req_rw_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    bus_request_d = bus_request_q;
    bus_rw_d      = bus_rw_q;
    bus_address_d = bus_address_q;
    bus_wdata_d   = bus_wdata_q;
    ram_we        = 1'b0;
    ram_addr      = req_idx;
    ram_wdata     = {req_tag, req_wdata_q};
    o_ready       = 1'b0;
    o_rdata       = 32'h0;
    flush_step    = 1'b0;

    case (state_q)
      IDLE: begin
        // A flush starts its walk at index 0, so prefetch that entry.
        ram_addr = i_flush ? '0 : i_address[SIZE+1:2];
        if (i_request) begin
          req_rw_d    = i_rw;
          req_addr_d  = i_address;
          req_wdata_d = i_wdata;
          flush_idx_d = '0;
          if (i_flush)                       state_d = FLUSH_SCAN;
          else if (i_address[UNCACHED_BIT])  state_d = UNCACHED;
          else                               state_d = CHECK;
        end
      end

      CHECK: begin
        if (hit) begin
          o_ready = 1'b1;
          state_d = IDLE;
          if (req_rw_q) begin
            ram_we           = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end else begin
            o_rdata = line_data;
          end
        end else if (victim_dirty) begin
          state_d = WRITEBACK;
        end else if (req_rw_q) begin
          // One-word lines: a write miss installs the line without a fill.
          ram_we           = 1'b1;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b1;
          o_ready          = 1'b1;
          state_d          = IDLE;
        end else begin
          state_d = FILL;
        end
      end

      WRITEBACK: begin
        if (!bus_request_q) begin
          bus_request_d = 1'b1;
          bus_rw_d      = 1'b1;
          bus_address_d = {line_tag, req_idx, 2'b00};
          bus_wdata_d   = line_data;
        end else if (i_bus_ready) begin
          bus_request_d    = 1'b0;
          dirty_d[req_idx] = 1'b0;
          if (req_rw_q) begin
            ram_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b1;
            o_ready          = 1'b1;
            state_d          = IDLE;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        if (!bus_request_q) begin
          bus_request_d = 1'b1;
          bus_rw_d      = 1'b0;
          bus_address_d = req_addr_q;
        end else if (i_bus_ready) begin
          bus_request_d    = 1'b0;
          ram_we           = 1'b1;
          ram_wdata        = {req_tag, i_bus_rdata};
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          o_ready          = 1'b1;
          o_rdata          = i_bus_rdata;
          state_d          = IDLE;
        end
      end

      UNCACHED: begin
        if (!bus_request_q) begin
          bus_request_d = 1'b1;
          bus_rw_d      = req_rw_q;
          bus_address_d = req_addr_q;
          bus_wdata_d   = req_wdata_q;
        end else if (i_bus_ready) begin
          bus_request_d = 1'b0;
          o_ready       = 1'b1;
          o_rdata       = req_rw_q ? 32'h0 : i_bus_rdata;
          state_d       = IDLE;
        end
      end

      FLUSH_SCAN: begin
        if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
          bus_request_d = 1'b1;
          bus_rw_d      = 1'b1;
          bus_address_d = {line_tag, flush_idx_q, 2'b00};
          bus_wdata_d   = line_data;
          state_d       = FLUSH_WB;
        end else begin
          flush_step = 1'b1;
        end
      end

      FLUSH_WB: begin
        if (bus_done) begin
          bus_request_d = 1'b0;
          flush_step    = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (flush_step) begin
      valid_d[flush_idx_q] = 1'b0;
      dirty_d[flush_idx_q] = 1'b0;
      if (&flush_idx_q) begin
        o_ready = 1'b1;
        state_d = IDLE;
      end else begin
        flush_idx_d = flush_idx_q + SIZE'(1);
        state_d     = FLUSH_SCAN;
      end
    end

    // During the walk the RAM reads the index that will be inspected next
    // cycle, so FLUSH_SCAN always sees the entry for flush_idx_q.
    if (state_q == FLUSH_SCAN || state_q == FLUSH_WB) begin
      ram_addr = flush_idx_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      dirty_q       <= '0;
      flush_idx_q   <= '0;
      req_rw_q      <= 1'b0;
      req_addr_q    <= 32'h0;
      req_wdata_q   <= 32'h0;
      bus_request_q <= 1'b0;
      bus_rw_q      <= 1'b0;
      bus_address_q <= 32'h0;
      bus_wdata_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      flush_idx_q   <= flush_idx_d;
      req_rw_q      <= req_rw_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      bus_request_q <= bus_request_d;
      bus_rw_q      <= bus_rw_d;
      bus_address_q <= bus_address_d;
      bus_wdata_q   <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_dcache.sv
// Directed bench for cpu_dcache (SIZE = 8). Client responses and bus
// transactions are predicted by hand and queued; a client monitor and a bus
// responder pop and compare as the DUT presents o_ready / bus requests.
module tb_cpu_dcache;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        o_bus_rw, o_bus_request;
  logic        i_bus_ready = 1'b0;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata = 32'h0;
  logic [31:0] o_bus_wdata;
  logic        i_rw = 1'b0, i_request = 1'b0, i_flush = 1'b0;
  logic        o_ready;
  logic [31:0] i_address = 32'h0, o_rdata, i_wdata = 32'h0;

  int checks = 0;
  int fails  = 0;
  int bus_wait = 1;
  int bus_cnt = 0;
  int bus_req_cycles = 0;
  int ready_count = 0;

  logic [32:0] exp_q[$];      // {check_rdata, rdata}
  logic [64:0] exp_bus_q[$];  // {rw, address, wdata}
  logic [32:0] mon_exp;
  logic [64:0] bus_exp;
  logic [31:0] bus_mem [logic [31:0]];

  cpu_dcache #(.SIZE(8)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .o_bus_rw      (o_bus_rw),
    .o_bus_request (o_bus_request),
    .i_bus_ready   (i_bus_ready),
    .o_bus_address (o_bus_address),
    .i_bus_rdata   (i_bus_rdata),
    .o_bus_wdata   (o_bus_wdata),
    .i_rw          (i_rw),
    .i_request     (i_request),
    .i_flush       (i_flush),
    .o_ready       (o_ready),
    .i_address     (i_address),
    .o_rdata       (o_rdata),
    .i_wdata       (i_wdata)
  );

  // ---------------- clock ----------------
  always #5 i_clock = ~i_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    case (a)
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0500: return 32'hCAFE_F00D;
      32'h0000_0104: return 32'h0BAD_F00D;
      default:       return 32'h0;
    endcase
  endfunction

  task automatic exp_bus(input logic rw, input logic [31:0] a, input logic [31:0] d);
    exp_bus_q.push_back({rw, a, d});
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the edge that ends the
  // o_ready cycle, with the request still asserted so the caller can chain.
  task automatic cpu_access(input logic rw, input logic flush, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic chk,
                            input logic [31:0] exp_rdata, input int budget, output int lat);
    int waited = 0;
    exp_q.push_back({chk, exp_rdata});
    i_request = 1'b1;
    i_rw      = rw;
    i_flush   = flush;
    i_address = addr;
    i_wdata   = wdata;
    lat = -1;
    while (waited < budget) begin
      @(negedge i_clock);
      waited++;
      if (o_ready) begin
        lat = waited - 1;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      fails++;
      $display("FAIL timeout addr=0x%08h: no o_ready within %0d cycles", addr, budget);
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    end
    @(posedge i_clock);
    #1;
  endtask

  task automatic cpu_idle();
    i_request = 1'b0;
    i_rw      = 1'b0;
    i_flush   = 1'b0;
  endtask

  // ---------------- client monitor / scoreboard ----------------
  always @(negedge i_clock) begin
    if (!i_reset && o_ready) begin
      ready_count++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ready: o_ready with rdata 0x%08h, none expected", o_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp[32]) check("rdata", o_rdata, mon_exp[31:0]);
      end
    end
  end

  always @(posedge i_clock) begin
    if (o_bus_request) bus_req_cycles++;
  end

  // ---------------- bus responder / bus scoreboard ----------------
  always begin
    @(posedge i_clock);
    #1;
    if (i_reset) begin
      i_bus_ready = 1'b0;
      bus_cnt = 0;
    end else if (i_bus_ready) begin
      i_bus_ready = 1'b0;
      i_bus_rdata = 32'h0;
    end else if (o_bus_request) begin
      if (bus_cnt < bus_wait) begin
        bus_cnt++;
      end else begin
        bus_cnt = 0;
        if (exp_bus_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_bus: rw=%0d addr=0x%08h, none expected", o_bus_rw, o_bus_address);
        end else begin
          bus_exp = exp_bus_q.pop_front();
          check("bus_rw", {31'h0, o_bus_rw}, {31'h0, bus_exp[64]});
          check("bus_addr", o_bus_address, bus_exp[63:32]);
          if (bus_exp[64]) check("bus_wdata", o_bus_wdata, bus_exp[31:0]);
        end
        if (o_bus_rw) bus_mem[o_bus_address] = o_bus_wdata;
        else          i_bus_rdata = mem_read(o_bus_address);
        i_bus_ready = 1'b1;
      end
    end
  end

  // ---------------- directed test ----------------
  initial begin
    int lat;
    int c0;
    int r0;
    int waited;

    repeat (3) @(posedge i_clock);
    #1;
    check("rst_bus_request", {31'h0, o_bus_request}, 32'h0);
    check("rst_bus_rw", {31'h0, o_bus_rw}, 32'h0);
    check("rst_ready", {31'h0, o_ready}, 32'h0);
    check("rst_bus_address", o_bus_address, 32'h0);
    check("rst_bus_wdata", o_bus_wdata, 32'h0);
    check("rst_rdata", o_rdata, 32'h0);
    @(negedge i_clock);
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;

    // Cold read, then repeat read hits with no bus traffic.
    bus_wait = 3;
    exp_bus(1'b0, 32'h100, 32'h0);
    cpu_access(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, 50, lat); cpu_idle();
    c0 = bus_req_cycles;
    cpu_access(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, 50, lat); cpu_idle();
    check("hit_latency", lat, 1);
    check("hit_no_bus", bus_req_cycles, c0);

    // Write hit, then read back.
    cpu_access(1'b1, 1'b0, 32'h100, 32'h1234_5678, 1'b0, 32'h0, 50, lat); cpu_idle();
    check("write_hit_latency", lat, 1);
    cpu_access(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h1234_5678, 50, lat); cpu_idle();
    check("write_hit_no_bus", bus_req_cycles, c0);

    // Dirty eviction: writeback of 0x100, then fill of 0x500.
    bus_wait = 2;
    exp_bus(1'b1, 32'h100, 32'h1234_5678);
    exp_bus(1'b0, 32'h500, 32'h0);
    cpu_access(1'b0, 1'b0, 32'h500, 32'h0, 1'b1, 32'hCAFE_F00D, 80, lat); cpu_idle();
    // 0x500 was filled clean: bringing 0x100 back needs no writeback.
    exp_bus(1'b0, 32'h100, 32'h0);
    cpu_access(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h1234_5678, 80, lat); cpu_idle();

    // Flush with dirty lines at 0x0 and 0x8.
    bus_wait = 1;
    cpu_access(1'b1, 1'b0, 32'h0, 32'h1111_1111, 1'b0, 32'h0, 50, lat); cpu_idle();
    cpu_access(1'b1, 1'b0, 32'h8, 32'h2222_2222, 1'b0, 32'h0, 50, lat); cpu_idle();
    exp_bus(1'b1, 32'h0, 32'h1111_1111);
    exp_bus(1'b1, 32'h8, 32'h2222_2222);
    r0 = ready_count;
    cpu_access(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 600, lat); cpu_idle();
    check("flush_min_length", {31'h0, lat >= 256}, 32'h1);
    check("flush_one_ready", ready_count - r0, 1);
    c0 = bus_req_cycles;
    exp_bus(1'b0, 32'h0, 32'h0);
    cpu_access(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1111_1111, 50, lat); cpu_idle();
    check("flush_then_miss", {31'h0, bus_req_cycles > c0}, 32'h1);

    // Uncached write, then two uncached reads that both reach the bus.
    exp_bus(1'b1, 32'h8000_0010, 32'h0000_00A5);
    cpu_access(1'b1, 1'b0, 32'h8000_0010, 32'h0000_00A5, 1'b0, 32'h0, 50, lat); cpu_idle();
    exp_bus(1'b0, 32'h8000_0010, 32'h0);
    cpu_access(1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b1, 32'h0000_00A5, 50, lat); cpu_idle();
    c0 = bus_req_cycles;
    exp_bus(1'b0, 32'h8000_0010, 32'h0);
    cpu_access(1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b1, 32'h0000_00A5, 50, lat); cpu_idle();
    check("uncached_again_bus", {31'h0, bus_req_cycles > c0}, 32'h1);

    // Reset in the middle of a fill of 0x104.
    bus_wait = 1000;
    i_request = 1'b1; i_rw = 1'b0; i_flush = 1'b0; i_address = 32'h104;
    waited = 0;
    while (waited < 20 && !o_bus_request) begin
      @(negedge i_clock);
      waited++;
    end
    check("midfill_bus_request", {31'h0, o_bus_request}, 32'h1);
    check("midfill_bus_addr", o_bus_address, 32'h104);
    i_reset = 1'b1;
    cpu_idle();
    @(posedge i_clock);
    #1;
    check("reset_drops_bus_request", {31'h0, o_bus_request}, 32'h0);
    @(negedge i_clock);
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;
    bus_wait = 2;
    c0 = bus_req_cycles;
    exp_bus(1'b0, 32'h104, 32'h0);
    cpu_access(1'b0, 1'b0, 32'h104, 32'h0, 1'b1, 32'h0BAD_F00D, 80, lat); cpu_idle();
    check("after_reset_miss", {31'h0, bus_req_cycles > c0}, 32'h1);

    // Back-to-back read-modify-write with the request held high.
    r0 = ready_count;
    cpu_access(1'b0, 1'b0, 32'h104, 32'h0, 1'b1, 32'h0BAD_F00D, 50, lat);
    cpu_access(1'b1, 1'b0, 32'h104, 32'h0BAD_F00E, 1'b0, 32'h0, 50, lat);
    cpu_idle();
    check("rmw_two_readies", ready_count - r0, 2);
    check("rmw_write_latency", lat, 1);
    cpu_access(1'b0, 1'b0, 32'h104, 32'h0, 1'b1, 32'h0BAD_F00E, 50, lat); cpu_idle();

    // Write miss over a dirty victim: writeback only, no fill.
    cpu_access(1'b1, 1'b0, 32'h508, 32'h0000_0055, 1'b0, 32'h0, 50, lat); cpu_idle();
    exp_bus(1'b1, 32'h508, 32'h0000_0055);
    cpu_access(1'b1, 1'b0, 32'h108, 32'h0000_0066, 1'b0, 32'h0, 80, lat); cpu_idle();
    cpu_access(1'b0, 1'b0, 32'h108, 32'h0, 1'b1, 32'h0000_0066, 50, lat); cpu_idle();
    check("wb_write_then_hit", lat, 1);

    repeat (5) @(posedge i_clock);
    check("client_queue_drained", exp_q.size(), 0);
    check("bus_queue_drained", exp_bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
